// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS/CTRL bit positions and transmitter state encoding.
package mmio_uart_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // STATUS bit positions; bit 9 mirrors "full" for older firmware polling a busy flag
  localparam int ST_FULL        = 0;
  localparam int ST_EMPTY       = 1;
  localparam int ST_BUSY        = 2;
  localparam int ST_OVERFLOW    = 3;
  localparam int ST_FULL_COMPAT = 9;
  localparam int ST_LEVEL_LSB   = 16;

  localparam int CTRL_TX_ENABLE = 0;
  localparam int CTRL_IRQ_EN    = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrapping pointers and a level counter one bit wider.
// Read data is registered on pop (read-first), so a full FIFO can take a push in the pop cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_reg == LEVEL_FULL);
  assign empty   = (level_reg == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Storage has no reset so it maps onto block RAM; reset only empties the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= wr_data;
    if (pop_ok)  rd_data_reg <= mem_reg[rd_ptr_reg];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rd_data = rd_data_reg;
  assign level   = level_reg;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIVISOR/CTRL registers,
// a TX FIFO and a bit-timed shifter with a level interrupt on "drained".
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int DIV_WIDTH    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] wdata,
  input  logic        wstrb,
  input  logic        rstrb,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(CLK_FREQ_HZ / DEFAULT_BAUD - 1);

  logic                 bus_ok_reg;
  logic [DIV_WIDTH-1:0] div_reg;
  logic                 tx_enable_reg;
  logic                 irq_en_reg;
  logic                 overflow_reg;
  logic [31:0]          rdata_reg;
  logic [31:0]          rdata_next;
  logic                 irq_reg;

  tx_state_e            state_reg, state_next;
  logic [DIV_WIDTH-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]           bit_cnt_reg, bit_cnt_next;
  logic [7:0]           shift_reg, shift_next;
  logic                 txd_reg, txd_next;

  logic                 wr_en, rd_en, push_req, push_acc, overflow_set;
  logic                 fifo_pop, fifo_full, fifo_empty, busy;
  logic [7:0]           fifo_rd_data;
  logic [LVL_W-1:0]     fifo_level;
  logic                 unused_wdata;

  // The first edge after reset release is a guard cycle: the bus is not sampled.
  assign wr_en        = sel & wstrb & bus_ok_reg;
  assign rd_en        = sel & rstrb & bus_ok_reg;
  assign push_req     = wr_en & (reg_addr == REG_DATA);
  assign push_acc     = push_req & (~fifo_full | fifo_pop);
  assign overflow_set = push_req & fifo_full & ~fifo_pop;
  assign busy         = (state_reg != S_IDLE);
  assign unused_wdata = ^wdata;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push_acc),
    .wr_data (wdata[7:0]),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    rdata_next = '0;
    case (reg_addr)
      REG_STATUS: begin
        rdata_next[ST_FULL]        = fifo_full;
        rdata_next[ST_EMPTY]       = fifo_empty;
        rdata_next[ST_BUSY]        = busy;
        rdata_next[ST_OVERFLOW]    = overflow_reg;
        rdata_next[ST_FULL_COMPAT] = fifo_full;
        rdata_next[ST_LEVEL_LSB +: LVL_W] = fifo_level;
      end
      REG_DIVISOR: rdata_next[DIV_WIDTH-1:0] = div_reg;
      REG_CTRL: begin
        rdata_next[CTRL_TX_ENABLE] = tx_enable_reg;
        rdata_next[CTRL_IRQ_EN]    = irq_en_reg;
      end
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_ok_reg    <= 1'b0;
      div_reg       <= DIV_RESET;
      tx_enable_reg <= 1'b1;
      irq_en_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      rdata_reg     <= '0;
      irq_reg       <= 1'b0;
    end else begin
      bus_ok_reg <= 1'b1;
      if (wr_en) begin
        case (reg_addr)
          REG_STATUS:  overflow_reg <= 1'b0;
          REG_DIVISOR: div_reg <= wdata[DIV_WIDTH-1:0];
          REG_CTRL: begin
            tx_enable_reg <= wdata[CTRL_TX_ENABLE];
            irq_en_reg    <= wdata[CTRL_IRQ_EN];
          end
          default: ;
        endcase
      end
      if (overflow_set) overflow_reg <= 1'b1;
      if (rd_en) rdata_reg <= rdata_next;
      irq_reg <= irq_en_reg & fifo_empty & ~busy;
    end
  end

  // Transmitter: the down-counter is reloaded from DIVISOR at every bit boundary,
  // so a DIVISOR write only affects the bit after the current one.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    fifo_pop      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (tx_enable_reg && !fifo_empty) begin
          state_next    = S_START;
          fifo_pop      = 1'b1;
          baud_cnt_next = div_reg;
        end
      end
      S_START: begin
        if (baud_cnt_reg == '0) begin
          state_next    = S_DATA;
          baud_cnt_next = div_reg;
          bit_cnt_next  = 3'd0;
          shift_next    = fifo_rd_data;
        end else begin
          baud_cnt_next = baud_cnt_reg - DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (baud_cnt_reg == '0) begin
          baud_cnt_next = div_reg;
          if (bit_cnt_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_cnt_next = baud_cnt_reg - DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (baud_cnt_reg == '0) begin
          if (tx_enable_reg && !fifo_empty) begin
            state_next    = S_START;
            fifo_pop      = 1'b1;
            baud_cnt_next = div_reg;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg - DIV_WIDTH'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase

    txd_next = 1'b1;
    case (state_next)
      S_START: txd_next = 1'b0;
      S_DATA:  txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      txd_reg      <= txd_next;
    end
  end

  assign rdata = rdata_reg;
  assign txd   = txd_reg;
  assign irq   = irq_reg;

endmodule
